// File: rtl/cam_cfg_sequencer_pkg.sv
// Shared types and constants for the camera configuration sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cam_cfg_sequencer_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE,
        WAIT_RSP,
        GAP,
        DELAY,
        DONE,
        FAIL
    } state_e;

    // Table entry that terminates the sequence early.
    localparam logic [15:0] END_MARK   = 16'hFFFF;
    // Register address that turns an entry into a millisecond delay.
    localparam logic [7:0]  DELAY_ADDR = 8'hFF;

endpackage

// File: rtl/cam_cfg_rom.sv
// Camera register list, {reg_addr, data} per entry; unlisted indices read END_MARK.
// Latency: 1 cycle from index to entry (registered output).
// Backpressure: none, the entry follows index every cycle.
module cam_cfg_rom
    import cam_cfg_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  index,
    output logic [15:0] entry
);

    logic [15:0] entry_d;
    logic [15:0] entry_q;

    // Table lookup: soft reset, settle delay, then the sensor setup list.
    always_comb begin
        entry_d = END_MARK;
        case (index)
            8'd0:    entry_d = 16'h1280;  // COM7: soft reset
            8'd1:    entry_d = 16'h1100;  // CLKRC: no prescale
            8'd2:    entry_d = 16'h3A04;  // TSLB: output sequence
            8'd3:    entry_d = 16'hFF05;  // wait 5 ms for the sensor to settle
            8'd4:    entry_d = 16'h40D0;  // COM15: full range RGB565
            8'd5:    entry_d = 16'hFF00;  // zero-length delay, advances at once
            8'd6:    entry_d = 16'h1714;  // HSTART
            8'd7:    entry_d = 16'h1802;  // HSTOP
            8'd8:    entry_d = 16'h3200;  // HREF
            default: entry_d = END_MARK;
        endcase
    end

    // Registered read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry = entry_q;

endmodule

// File: rtl/cam_cfg_sequencer.sv
// Walks the camera register table and issues SCCB writes, with retries, delays and gaps.
// Latency: first command 3 cycles after reset release or start; GAP_CYCLES idle after each response.
// Backpressure: cmd_valid is registered and held with stable fields until cmd_ready.
module cam_cfg_sequencer
    import cam_cfg_sequencer_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR     = 8'h42,
    parameter int         TABLE_LEN    = 64,
    parameter int         GAP_CYCLES   = 10,
    parameter int         TICKS_PER_MS = 1000,
    parameter int         MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_dev_addr,
    output logic [7:0] cmd_reg_addr,
    output logic [7:0] cmd_data,
    input  logic       rsp_valid,
    input  logic       rsp_nack,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] err_index
);

    // Counter covers the longest delay (255 ms) but never drops below 18 bits.
    localparam int DLY_MAX = 255 * TICKS_PER_MS;
    localparam int CNT_W   = ($clog2(DLY_MAX + 1) > 18) ? $clog2(DLY_MAX + 1) : 18;

    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TICKS_C  = CNT_W'(TICKS_PER_MS);
    localparam logic [8:0]       LEN_C    = 9'(TABLE_LEN);
    localparam logic [7:0]       RETRY_C  = 8'(MAX_RETRY);

    state_e           state_d, state_q;
    logic [7:0]       idx_d, idx_q;
    logic [7:0]       retry_d, retry_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [7:0]       reg_d, reg_q;
    logic [7:0]       dat_d, dat_q;
    logic [7:0]       err_index_d, err_index_q;
    logic             cmd_valid_q, busy_q, done_q, error_q;

    logic [15:0]      entry;
    logic [8:0]       idx_inc;
    logic [CNT_W-1:0] dly_prod;

    cam_cfg_rom u_rom (
        .clk   (clk),
        .reset (reset),
        .index (idx_q),
        .entry (entry)
    );

    // Nine bits so that TABLE_LEN = 256 is reachable without the index wrapping.
    assign idx_inc  = {1'b0, idx_q} + 9'd1;
    assign dly_prod = CNT_W'(entry[7:0]) * TICKS_C;

    // Next-state logic. After GAP, a zero retry count means the last write was
    // acknowledged (advance); a non-zero count means re-issue the same entry.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        cnt_d       = cnt_q;
        reg_d       = reg_q;
        dat_d       = dat_q;
        err_index_d = err_index_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                idx_d   = '0;
                retry_d = '0;
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                if (entry == END_MARK) begin
                    state_d = DONE;
                end else if (entry[15:8] == DELAY_ADDR) begin
                    state_d = DELAY;
                    cnt_d   = (entry[7:0] == 8'd0) ? '0 : dly_prod - CNT_W'(1);
                end else begin
                    state_d = ISSUE;
                    reg_d   = entry[15:8];
                    dat_d   = entry[7:0];
                end
            end
            ISSUE: if (cmd_ready) state_d = WAIT_RSP;
            WAIT_RSP: begin
                if (rsp_valid) begin
                    if (!rsp_nack) begin
                        retry_d = '0;
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end else if (retry_q != RETRY_C) begin
                        retry_d = retry_q + 8'd1;
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d     = FAIL;
                        err_index_d = idx_q;
                    end
                end
            end
            GAP, DELAY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (state_q == GAP && retry_q != 8'd0) begin
                    state_d = ISSUE;
                end else if (idx_inc == LEN_C) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_inc[7:0];
                    state_d = FETCH;
                end
            end
            DONE, FAIL: begin
                if (start) begin
                    state_d     = FETCH;
                    idx_d       = '0;
                    retry_d     = '0;
                    err_index_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered status outputs derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            retry_q     <= '0;
            cnt_q       <= '0;
            reg_q       <= '0;
            dat_q       <= '0;
            err_index_q <= '0;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            cnt_q       <= cnt_d;
            reg_q       <= reg_d;
            dat_q       <= dat_d;
            err_index_q <= err_index_d;
            cmd_valid_q <= (state_d == ISSUE);
            busy_q      <= (state_d != DONE) && (state_d != FAIL);
            done_q      <= (state_d == DONE);
            error_q     <= (state_d == FAIL);
        end
    end

    assign cmd_valid    = cmd_valid_q;
    assign cmd_dev_addr = DEV_ADDR;
    assign cmd_reg_addr = reg_q;
    assign cmd_data     = dat_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_index    = err_index_q;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Randomized bench for cam_cfg_sequencer: one instance ends on table length, one on the end marker.
// Latency: expected cycle timing comes from a table-walking reference model.
// Backpressure: cmd_ready randomized, with stretches held low.
module tb_cam_cfg_sequencer;

    localparam int GAP   = 10;
    localparam int TICKS = 4;
    localparam int MAXR  = 3;
    localparam int LEN_A = 9;
    localparam int LEN_B = 64;
    localparam int NRUNS = 7;
    localparam int LIMIT = 20000;

    localparam int PH_ISSUE = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_END   = 2;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic start     = 1'b0;
    logic cmd_ready = 1'b0;
    logic rsp_valid = 1'b0;
    logic rsp_nack  = 1'b0;

    logic       cmd_valid    [2];
    logic [7:0] cmd_dev_addr [2];
    logic [7:0] cmd_reg_addr [2];
    logic [7:0] cmd_data     [2];
    logic [7:0] err_index    [2];
    logic       busy         [2];
    logic       done         [2];
    logic       error        [2];

    always #5 clk = ~clk;

    cam_cfg_sequencer #(.DEV_ADDR(8'h42), .TABLE_LEN(LEN_A), .GAP_CYCLES(GAP),
                        .TICKS_PER_MS(TICKS), .MAX_RETRY(MAXR)) u_dut_len (
        .clk(clk), .reset(reset), .start(start),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready), .cmd_dev_addr(cmd_dev_addr[0]),
        .cmd_reg_addr(cmd_reg_addr[0]), .cmd_data(cmd_data[0]),
        .rsp_valid(rsp_valid), .rsp_nack(rsp_nack),
        .busy(busy[0]), .done(done[0]), .error(error[0]), .err_index(err_index[0])
    );

    cam_cfg_sequencer #(.DEV_ADDR(8'h42), .TABLE_LEN(LEN_B), .GAP_CYCLES(GAP),
                        .TICKS_PER_MS(TICKS), .MAX_RETRY(MAXR)) u_dut_mark (
        .clk(clk), .reset(reset), .start(start),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready), .cmd_dev_addr(cmd_dev_addr[1]),
        .cmd_reg_addr(cmd_reg_addr[1]), .cmd_data(cmd_data[1]),
        .rsp_valid(rsp_valid), .rsp_nack(rsp_nack),
        .busy(busy[1]), .done(done[1]), .error(error[1]), .err_index(err_index[1])
    );

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [15:0] tab [0:9];

    int   phase, cur_idx, cur_retry, exp_at, rsp_cnt, run, hs_in_run;
    int   end_at [2];
    bit   end_fail, hs_pend, finished, nk, reached;
    bit   rst_taken [NRUNS];
    logic exp_v;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic [15:0] tab_at(input int i);
        if (i < 10) return tab[i];
        return 16'hFFFF;
    endfunction

    // Status outputs and cmd_valid of one instance.
    task automatic check_unit(input int u, input logic e_busy, input logic e_done,
                              input logic e_err, input logic [7:0] e_eidx, input logic e_vld);
        check_eq($sformatf("u%0d.cmd_valid", u), 32'(cmd_valid[u]), 32'(e_vld));
        check_eq($sformatf("u%0d.busy", u),      32'(busy[u]),      32'(e_busy));
        check_eq($sformatf("u%0d.done", u),      32'(done[u]),      32'(e_done));
        check_eq($sformatf("u%0d.error", u),     32'(error[u]),     32'(e_err));
        check_eq($sformatf("u%0d.err_index", u), 32'(err_index[u]), 32'(e_eidx));
    endtask

    task automatic check_zero(input string tag);
        for (int u = 0; u < 2; u++) begin
            check_unit(u, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
            check_eq($sformatf("%s.u%0d.reg", tag, u),  32'(cmd_reg_addr[u]), 32'd0);
            check_eq($sformatf("%s.u%0d.data", tag, u), 32'(cmd_data[u]),     32'd0);
        end
    endtask

    // Walk the table from start_idx; the fetch of start_idx happens at cycle t0+1.
    task automatic predict(input int len, input int start_idx, input int t0,
                           output bit is_done, output int idx_o, output int at_o);
        int i;
        int t;
        int d;
        logic [15:0] e;
        i = start_idx;
        t = t0;
        is_done = 1'b0;
        idx_o = 0;
        at_o = 0;
        while (1) begin
            if (i >= len) begin
                is_done = 1'b1; at_o = t + 1; return;
            end
            e = tab_at(i);
            if (e == 16'hFFFF) begin
                is_done = 1'b1; at_o = t + 3; return;
            end
            if (e[15:8] == 8'hFF) begin
                d = (e[7:0] == 8'd0) ? 1 : int'(e[7:0]) * TICKS;
                t = t + 2 + d;
                i++;
            end else begin
                idx_o = i; at_o = t + 3; return;
            end
        end
    endtask

    task automatic plan(input int start_idx, input int t0);
        bit dn;
        int ix;
        int at;
        predict(LEN_A, start_idx, t0, dn, ix, at);
        cur_retry = 0;
        if (!dn) begin
            phase = PH_ISSUE; cur_idx = ix; exp_at = at;
        end else begin
            phase = PH_END; end_fail = 1'b0; end_at[0] = at;
            predict(LEN_B, start_idx, t0, dn, ix, at);
            end_at[1] = at;
        end
    endtask

    // Assert reset (asynchronously, caller places it between edges), hold, release on a negedge.
    task automatic pulse_reset(input int hold);
        reset = 1'b0; start = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0;
        #1;
        check_zero("rst_async");
        for (int k = 0; k < hold; k++) begin
            next_cyc();
            check_zero("rst_hold");
        end
        next_cyc();
        reset = 1'b1;
        hs_pend = 1'b0;
        hs_in_run = 0;
        plan(0, cyc);
    endtask

    initial begin
        tab[0] = 16'h1280; tab[1] = 16'h1100; tab[2] = 16'h3A04; tab[3] = 16'hFF05;
        tab[4] = 16'h40D0; tab[5] = 16'hFF00; tab[6] = 16'h1714; tab[7] = 16'h1802;
        tab[8] = 16'h3200; tab[9] = 16'hFFFF;
        run = 0; finished = 1'b0; hs_pend = 1'b0; hs_in_run = 0;
        #1;
        pulse_reset(3);

        while (!finished && cyc < LIMIT) begin
            next_cyc();
            if (phase == PH_ISSUE && hs_pend) begin
                phase = PH_WAIT; hs_in_run++; rsp_cnt = $urandom_range(0, 5);
            end
            hs_pend   = 1'b0;
            start     = 1'b0;
            rsp_valid = 1'b0;
            rsp_nack  = 1'b0;
            cmd_ready = 1'($urandom_range(0, 1));

            case (phase)
                PH_ISSUE: begin
                    exp_v = (cyc >= exp_at);
                    for (int u = 0; u < 2; u++) begin
                        check_unit(u, 1'b1, 1'b0, 1'b0, 8'd0, exp_v);
                        if (exp_v) begin
                            check_eq($sformatf("u%0d.dev", u),  32'(cmd_dev_addr[u]), 32'h42);
                            check_eq($sformatf("u%0d.reg", u),  32'(cmd_reg_addr[u]), 32'(tab_at(cur_idx) >> 8));
                            check_eq($sformatf("u%0d.data", u), 32'(cmd_data[u]),     32'(tab_at(cur_idx) & 16'h00FF));
                        end
                    end
                    if (run == 3 && cyc < exp_at + 7) cmd_ready = 1'b0;
                    if ($urandom_range(0, 4) == 0) begin
                        rsp_valid = 1'b1; rsp_nack = 1'($urandom_range(0, 1));
                    end
                    if ($urandom_range(0, 9) == 0) start = 1'b1;
                    hs_pend = exp_v && cmd_ready;
                    if (run == 5 && !rst_taken[run] && exp_v && hs_in_run == 1) begin
                        rst_taken[run] = 1'b1;
                        #3;
                        pulse_reset(2);
                    end
                end
                PH_WAIT: begin
                    for (int u = 0; u < 2; u++) check_unit(u, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
                    if ($urandom_range(0, 9) == 0) start = 1'b1;
                    if (run == 4 && !rst_taken[run] && hs_in_run == 2) begin
                        rst_taken[run] = 1'b1;
                        #3;
                        pulse_reset(3);
                    end else if (rsp_cnt > 0) begin
                        rsp_cnt--;
                    end else begin
                        case (run)
                            0:       nk = 1'b0;
                            1:       nk = (cur_idx == 1) && (cur_retry < 3);
                            2:       nk = (cur_idx == 2);
                            default: nk = ($urandom_range(0, 99) < 25);
                        endcase
                        rsp_valid = 1'b1;
                        rsp_nack  = nk;
                        if (!nk) begin
                            plan(cur_idx + 1, cyc + GAP);
                        end else if (cur_retry < MAXR) begin
                            cur_retry++; exp_at = cyc + GAP + 1; phase = PH_ISSUE;
                        end else begin
                            phase = PH_END; end_fail = 1'b1;
                            end_at[0] = cyc + 1; end_at[1] = cyc + 1;
                        end
                    end
                end
                default: begin
                    for (int u = 0; u < 2; u++) begin
                        reached = (cyc >= end_at[u]);
                        check_unit(u, !reached, reached && !end_fail, reached && end_fail,
                                   (reached && end_fail) ? 8'(cur_idx) : 8'd0, 1'b0);
                    end
                    if ($urandom_range(0, 3) == 0) begin
                        rsp_valid = 1'b1; rsp_nack = 1'($urandom_range(0, 1));
                    end
                    if (cyc >= ((end_at[0] > end_at[1]) ? end_at[0] : end_at[1]) + 4) begin
                        if (run == NRUNS - 1) begin
                            finished = 1'b1;
                        end else begin
                            start = 1'b1; run++; hs_in_run = 0;
                            plan(0, cyc);
                        end
                    end
                end
            endcase
        end

        check_eq("finished", 32'(finished), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
